// File: rtl/systolic_matmul_nxn_if.sv
// Operand stream, result drain and control signals of the systolic matmul engine.
interface systolic_matmul_nxn_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 255
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);

  logic                start;
  logic [KW-1:0]       k_len;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] a_col;
  logic [N*DATA_W-1:0] b_row;
  logic                c_valid;
  logic                c_ready;
  logic [RW-1:0]       c_row;
  logic [N*ACC_W-1:0]  c_data;
  logic                busy;
  logic                done;

  modport master (output start, k_len, in_valid, a_col, b_row, c_ready,
                  input  in_ready, c_valid, c_row, c_data, busy, done);
  modport slave  (input  start, k_len, in_valid, a_col, b_row, c_ready,
                  output in_ready, c_valid, c_row, c_data, busy, done);
endinterface

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary NxN systolic matmul: skewed operand injection, per-PE MAC,
// start/busy/done FSM and row-by-row result drain.
module smm_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

  // wraps modulo 2^ACC_W on purpose
  always_ff @(posedge clk or posedge rst)
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= acc + ACC_W'(prod);
endmodule

module systolic_matmul_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 255
) (
  input logic clk,
  input logic rst,
  systolic_matmul_nxn_if.slave io
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t        st;
  logic [KW-1:0] klen, kcnt;
  logic [FW-1:0] fcnt;
  logic          rdy_q, cv_q, busy_q, done_q;
  logic [RW-1:0] row_q;
  logic          beat, clr;

  logic [N-1:0][DATA_W-1:0]        a_inj, b_inj, a_sk, b_sk;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_pe, b_pe;
  logic [N-1:0][N-2:0][DATA_W-1:0] a_fw, b_fw;
  logic [N-1:0][N-1:0][ACC_W-1:0]  acc;

  assign beat  = io.in_valid & rdy_q;
  assign clr   = (st == IDLE) & io.start;
  // idle cycles inject zeros so timing alignment never depends on in_valid
  assign a_inj = beat ? io.a_col : '0;
  assign b_inj = beat ? io.b_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_l0
      assign a_sk[0] = a_inj[0];
      assign b_sk[0] = b_inj[0];
    end else begin : g_ln
      logic [i-1:0][DATA_W-1:0] da, db;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          da <= '0; db <= '0;
        end else if (clr) begin
          da <= '0; db <= '0;
        end else begin
          da[0] <= a_inj[i];
          db[0] <= b_inj[i];
          for (int k = 1; k < i; k++) begin
            da[k] <= da[k-1];
            db[k] <= db[k-1];
          end
        end
      assign a_sk[i] = da[i-1];
      assign b_sk[i] = db[i-1];
    end
  end

  // a_fw[i][j]: A leaving PE(i,j) rightward; b_fw[j][i]: B leaving PE(i,j) downward
  always_comb begin
    a_pe = '0;
    b_pe = '0;
    for (int i = 0; i < N; i++) begin
      a_pe[i][0] = a_sk[i];
      b_pe[0][i] = b_sk[i];
      for (int j = 1; j < N; j++) begin
        a_pe[i][j] = a_fw[i][j-1];
        b_pe[j][i] = b_fw[i][j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_fw <= '0; b_fw <= '0;
    end else if (clr) begin
      a_fw <= '0; b_fw <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++) begin
          a_fw[i][j] <= a_pe[i][j];
          b_fw[i][j] <= b_pe[j][i];
        end
    end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      smm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .a   (a_pe[i][j]),
        .b   (b_pe[i][j]),
        .acc (acc[i][j])
      );
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE; klen <= '0; kcnt <= '0; fcnt <= '0;
      rdy_q <= 1'b0; cv_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; row_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: if (io.start) begin
          klen   <= io.k_len;
          kcnt   <= '0;
          fcnt   <= '0;
          busy_q <= 1'b1;
          if (io.k_len != '0) begin
            st    <= LOAD;
            rdy_q <= 1'b1;
          end else begin
            st    <= FLUSH;
          end
        end
        LOAD: if (beat) begin
          kcnt <= kcnt + KW'(1);
          if (kcnt == klen - KW'(1)) begin
            rdy_q <= 1'b0;
            st    <= FLUSH;
          end
        end
        // 2N-1 cycles lets the last beat reach PE(N-1,N-1)
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == FW'(2 * N - 2)) begin
            st    <= DRAIN;
            cv_q  <= 1'b1;
            row_q <= '0;
          end
        end
        DRAIN: if (io.c_ready) begin
          if (row_q == RW'(N - 1)) begin
            cv_q   <= 1'b0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            row_q  <= '0;
            st     <= IDLE;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end

  assign io.in_ready = rdy_q;
  assign io.c_valid  = cv_q;
  assign io.c_row    = row_q;
  assign io.c_data   = acc[row_q];
  assign io.busy     = busy_q;
  assign io.done     = done_q;
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench for systolic_matmul_nxn: default 32-bit instance plus an
// ACC_W=16 instance fed the same stimulus to exercise accumulator wrap.
module tb_systolic_matmul_nxn;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, c_ready;
  logic [7:0]  k_len;
  logic [31:0] a_col, b_row;

  int nchk, nerr;
  logic [31:0] a_b [8];
  logic [31:0] b_b [8];
  int exp_c [4][4];
  int exp1_v;

  always #5 clk = ~clk;

  systolic_matmul_nxn_if #(.N(4), .DATA_W(8), .ACC_W(32), .K_MAX(255)) if0 ();
  systolic_matmul_nxn_if #(.N(4), .DATA_W(8), .ACC_W(16), .K_MAX(255)) if1 ();

  assign if0.start = start;    assign if1.start = start;
  assign if0.k_len = k_len;    assign if1.k_len = k_len;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.a_col = a_col;    assign if1.a_col = a_col;
  assign if0.b_row = b_row;    assign if1.b_row = b_row;
  assign if0.c_ready = c_ready; assign if1.c_ready = c_ready;

  systolic_matmul_nxn #(.N(4), .DATA_W(8), .ACC_W(32), .K_MAX(255)) dut0 (
    .clk (clk), .rst (rst), .io (if0));
  systolic_matmul_nxn #(.N(4), .DATA_W(8), .ACC_W(16), .K_MAX(255)) dut1 (
    .clk (clk), .rst (rst), .io (if1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] row_vec(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(exp_c[r][j]);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_rst(input string tag);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    #1;
    chk({tag, "_busy"},     if0.busy, 0);
    chk({tag, "_in_ready"}, if0.in_ready, 0);
    chk({tag, "_c_valid"},  if0.c_valid, 0);
    chk({tag, "_done"},     if0.done, 0);
    chk({tag, "_c_data"},   if0.c_data, 0);
    tick;
    rst = 1'b0;
    tick;
  endtask

  // abort: 0 none, 1 reset after two beats, 2 reset once draining starts
  task automatic run_tile(input int k, input bit bubble, input int stall_row,
                          input bit busy_start, input bit chk1, input int cv_cyc,
                          input int abort);
    int cyc, got, t;
    bit acc;
    logic [127:0] held;
    k_len = 8'(k); start = 1'b1; in_valid = 1'b0; c_ready = 1'b1;
    tick;
    start = 1'b0; cyc = 1; got = 0; t = 0;
    chk("busy_after_start", if0.busy, 1);
    chk("in_ready_after_start", if0.in_ready, (k != 0) ? 1 : 0);
    while (got < k && t < 200) begin
      if (abort == 1 && got == 2) begin
        do_rst("rst_mid_load");
        return;
      end
      in_valid = bubble ? ((cyc % 2) == 0) : 1'b1;
      a_col = a_b[got]; b_row = b_b[got];
      if (busy_start && got == 1) begin start = 1'b1; k_len = 8'd1; end
      acc = in_valid && if0.in_ready;
      tick;
      start = 1'b0; cyc++; t++;
      if (acc) got++;
    end
    chk("beats_accepted", got, k);
    chk("in_ready_after_last", if0.in_ready, 0);
    in_valid = (k == 0);
    a_col = '1; b_row = '1;
    t = 0;
    while (!if0.c_valid && t < 200) begin tick; cyc++; t++; end
    in_valid = 1'b0;
    chk("c_valid_seen", if0.c_valid, 1);
    if (cv_cyc >= 0) chk("first_c_valid_cycle", cyc, cv_cyc);
    if (abort == 2) begin
      do_rst("rst_mid_drain");
      return;
    end
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        c_ready = 1'b0;
        held = if0.c_data;
        for (int s = 0; s < 3; s++) begin
          chk("stall_c_row", if0.c_row, r);
          chk("stall_c_data_stable", if0.c_data, held);
          tick;
        end
        c_ready = 1'b1;
      end
      chk("row_c_valid", if0.c_valid, 1);
      chk("row_index", if0.c_row, r);
      chk("row_done_low", if0.done, 0);
      chk($sformatf("row%0d_data", r), if0.c_data, row_vec(r));
      if (chk1) chk($sformatf("acc16_row%0d_data", r), if1.c_data, {4{16'(exp1_v)}});
      tick;
    end
    chk("done_pulse", if0.done, 1);
    chk("c_valid_with_done", if0.c_valid, 0);
    chk("busy_with_done", if0.busy, 0);
    tick;
    chk("done_one_cycle", if0.done, 0);
  endtask

  task automatic load_ramp;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        a_b[k][i*8 +: 8] = 8'(i + k + 1);
        b_b[k][i*8 +: 8] = 8'(k + i + 5);
      end
    exp_c = '{'{70, 80, 90, 100}, '{96, 110, 124, 138},
              '{122, 140, 158, 176}, '{148, 170, 192, 214}};
  endtask

  initial begin
    nchk = 0; nerr = 0;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; c_ready = 1'b0;
    a_col = '0; b_row = '0; exp1_v = 0;
    for (int k = 0; k < 8; k++) begin a_b[k] = '0; b_b[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", if0.busy, 0);
    chk("reset_in_ready", if0.in_ready, 0);
    chk("reset_c_valid", if0.c_valid, 0);
    chk("reset_done", if0.done, 0);
    chk("reset_c_row", if0.c_row, 0);
    chk("reset_c_data", if0.c_data, 0);
    rst = 1'b0;
    tick;

    load_ramp();
    run_tile(4, 0, -1, 0, 0, 12, 0);   // back-to-back beats
    run_tile(4, 1, -1, 0, 0, -1, 0);   // bubble on alternate cycles
    run_tile(4, 0, 1, 0, 0, 12, 0);    // backpressure on row 1

    for (int k = 0; k < 4; k++) begin a_b[k] = {4{8'h80}}; b_b[k] = {4{8'h80}}; end
    foreach (exp_c[r, j]) exp_c[r][j] = 65536;
    exp1_v = 0;
    run_tile(4, 0, -1, 0, 1, 12, 0);   // -128*-128*4, wraps to 0 at ACC_W=16

    foreach (exp_c[r, j]) exp_c[r][j] = 0;
    run_tile(0, 0, -1, 0, 0, 8, 0);    // empty inner dimension

    load_ramp();
    run_tile(4, 0, -1, 0, 0, -1, 1);
    run_tile(4, 0, -1, 1, 0, 12, 0);   // start pulsed while busy must be ignored
    run_tile(4, 0, -1, 0, 0, -1, 2);
    run_tile(4, 0, -1, 0, 0, 12, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
